elevator_ctrl: RTL and testbench
================================

ELEVATOR_CTRL -- requirements
Module: elevator_ctrl

Interface
REQ-001 The block SHALL have parameter FLOORS, default 8, meaning number of floors (2..16).
REQ-002 The block SHALL have parameter TRAVEL_CYCLES, default 4, meaning CLK cycles per one-floor move (>=1).
REQ-003 The block SHALL have parameter DOOR_CYCLES, default 3, meaning CLK cycles the door stays open (>=1).
REQ-004 The block SHALL have local parameter FW = clog2(FLOORS), the floor index width.
REQ-005 The block SHALL have these ports:
- CLK  input  1  clock; all logic rising-edge.
- RESET  input  1  reset.
- Call_Req  input  FLOORS  per-floor call, level-sampled each cycle.
- Halt  input  1  emergency stop, level.
- Top_Limit_Hit  input  1  car at top limit switch.
- Bottom_Limit_Hit  input  1  car at bottom limit switch.
- Go_Up  output  1  motor up.
- Go_Down  output  1  motor down.
- Door_Open  output  1  door actuator.
- Floor  output  FW  current floor index.
- state  output  5  one-hot FSM state.
REQ-006 The block SHALL use one clock, CLK; RESET SHALL be asynchronous and active-high.

Function
REQ-007 The block SHALL encode state as IDLE=00001, UP=00010, DOWN=00100, DOOR=01000, HALTED=10000, and SHALL drive every output from a register.
REQ-008 The block SHALL OR Call_Req into a pending[FLOORS-1:0] register each cycle, except in DOOR, where a call at Floor SHALL restart the door timer instead of setting pending.
REQ-009 In IDLE the block SHALL pick a target; target>Floor -> UP, target<Floor -> DOWN, target==Floor -> DOOR; no pending -> stay in IDLE.
REQ-010 In UP, Go_Up=1; the travel counter SHALL count TRAVEL_CYCLES, then Floor += 1 and the counter clears; if pending[new Floor] -> DOOR, else stay in UP.
REQ-011 DOWN SHALL mirror UP with Go_Down=1 and Floor -= 1.
REQ-012 Go_Up and Go_Down SHALL never both be 1.
REQ-013 UP SHALL never increment past FLOORS-1 and DOWN SHALL never decrement below 0; on reaching either end with no pending call there, the block SHALL go to IDLE.
REQ-014 On entry to DOOR the block SHALL clear pending[Floor] and hold Door_Open=1 for exactly DOOR_CYCLES cycles, then go to IDLE.
REQ-015 Top_Limit_Hit SHALL force Floor=FLOORS-1, and Bottom_Limit_Hit SHALL force Floor=0, in any state except HALTED; from UP/DOWN the next state is DOOR if pending there, else IDLE.
REQ-016 If both limit inputs are high in the same cycle, the block SHALL treat it as a fault and go to HALTED.
REQ-017 Halt=1 SHALL take every state to HALTED on the next edge, with Go_Up=Go_Down=Door_Open=0 and the travel and door counters cleared.
REQ-018 While in HALTED, pending SHALL keep accumulating; HALTED -> IDLE on the first cycle Halt=0 and no double-limit condition.
REQ-019 Same-cycle priority SHALL be: Halt/double-limit > single limit > counter expiry > new call.

Reset
REQ-020 While RESET=1 the block SHALL hold: state=IDLE, Floor=0, pending=0, counters=0, Go_Up=Go_Down=Door_Open=0.
REQ-021 RESET asserted mid-move or mid-door SHALL abort immediately (asynchronously) with no partial Floor update.
REQ-022 After RESET deasserts, the first action SHALL occur on the following CLK edge.

Configuration
REQ-023 Macro ELEVATOR_SCAN_EN SHALL select the target policy.
- Defined: keep the last travel direction; the target is the nearest pending floor in that direction, and the direction reverses only when none remain.
- Undefined: the target is always the lowest-index pending floor.

Verification
REQ-024 Reset, Call_Req[3] pulse -> UP for 3*TRAVEL_CYCLES=12 cycles, Floor=3, DOOR for 3 cycles, IDLE, pending[3]=0.
REQ-025 At Floor 3, Halt high during UP at cycle 2 of travel -> next edge HALTED, Go_Up=0, Floor=3; Halt low -> IDLE, then resumes to pending target.
REQ-026 Call_Req[7] while UP at Floor 2, then Top_Limit_Hit -> Floor=7, DOOR, pending[7]=0.
REQ-027 Calls at 1 and 5, car at 3, last direction UP -> with ELEVATOR_SCAN_EN visits 5 then 1; without it visits 1 then 5.
REQ-028 Top_Limit_Hit=Bottom_Limit_Hit=1 -> HALTED, all motor/door outputs 0; RESET asserted during DOOR -> outputs 0 and state=00001 without waiting for a clock edge.

Source files
------------

// File: rtl/elevator_ctrl.sv
// Elevator car controller: call latching, per-floor travel timing, door timing, limit switches and emergency halt.
// Optional macro ELEVATOR_SCAN_EN selects the directional scan target policy (default: lowest pending floor first).
module elevator_ctrl #(
    parameter int unsigned FLOORS        = 8,
    parameter int unsigned TRAVEL_CYCLES = 4,
    parameter int unsigned DOOR_CYCLES   = 3,
    localparam int unsigned FW           = $clog2(FLOORS)
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic [FLOORS-1:0] Call_Req,
    input  logic              Halt,
    input  logic              Top_Limit_Hit,
    input  logic              Bottom_Limit_Hit,
    output logic              Go_Up,
    output logic              Go_Down,
    output logic              Door_Open,
    output logic [FW-1:0]     Floor,
    output logic [4:0]        state
);

    localparam int unsigned TW = $clog2(TRAVEL_CYCLES) + 1;
    localparam int unsigned DW = $clog2(DOOR_CYCLES) + 1;

    localparam logic [4:0] S_IDLE   = 5'b00001;
    localparam logic [4:0] S_UP     = 5'b00010;
    localparam logic [4:0] S_DOWN   = 5'b00100;
    localparam logic [4:0] S_DOOR   = 5'b01000;
    localparam logic [4:0] S_HALTED = 5'b10000;

    localparam logic [FW-1:0] TOP_FLOOR   = FW'(FLOORS - 1);
    localparam logic [TW-1:0] TRAVEL_LAST = TW'(TRAVEL_CYCLES - 1);
    localparam logic [DW-1:0] DOOR_LAST   = DW'(DOOR_CYCLES - 1);

    logic [4:0]        state_q, state_d;
    logic [FW-1:0]     floor_q, floor_d;
    logic [FLOORS-1:0] pending_q, pending_d;
    logic [TW-1:0]     travel_q, travel_d;
    logic [DW-1:0]     door_q, door_d;
    logic              go_up_q, go_up_d;
    logic              go_dn_q, go_dn_d;
    logic              door_open_q, door_open_d;
    logic [FW-1:0]     target;
    logic              has_pend;
    logic              dbl_limit;

    assign dbl_limit = Top_Limit_Hit && Bottom_Limit_Hit;

`ifdef ELEVATOR_SCAN_EN
    logic          dir_up_q, dir_up_d;
    logic          above_ok, below_ok;
    logic [FW-1:0] above_tgt, below_tgt;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) dir_up_q <= 1'b1;
        else       dir_up_q <= dir_up_d;
    end

    // Nearest pending floor in the remembered direction; reverse only when that side is empty
    always_comb begin
        has_pend  = |pending_q;
        above_ok  = 1'b0;
        below_ok  = 1'b0;
        above_tgt = floor_q;
        below_tgt = floor_q;
        for (int i = int'(FLOORS) - 1; i >= 0; i--) begin
            if (pending_q[i] && (FW'(i) > floor_q)) begin
                above_ok  = 1'b1;
                above_tgt = FW'(i);
            end
        end
        for (int i = 0; i < int'(FLOORS); i++) begin
            if (pending_q[i] && (FW'(i) < floor_q)) begin
                below_ok  = 1'b1;
                below_tgt = FW'(i);
            end
        end
        if (pending_q[floor_q]) target = floor_q;
        else if (dir_up_q)      target = above_ok ? above_tgt : below_tgt;
        else                    target = below_ok ? below_tgt : above_tgt;
    end
`else
    // Lowest-index pending floor wins
    always_comb begin
        has_pend = |pending_q;
        target   = floor_q;
        for (int i = int'(FLOORS) - 1; i >= 0; i--) begin
            if (pending_q[i]) target = FW'(i);
        end
    end
`endif

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q     <= S_IDLE;
            floor_q     <= '0;
            pending_q   <= '0;
            travel_q    <= '0;
            door_q      <= '0;
            go_up_q     <= 1'b0;
            go_dn_q     <= 1'b0;
            door_open_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            floor_q     <= floor_d;
            pending_q   <= pending_d;
            travel_q    <= travel_d;
            door_q      <= door_d;
            go_up_q     <= go_up_d;
            go_dn_q     <= go_dn_d;
            door_open_q <= door_open_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        floor_d   = floor_q;
        pending_d = pending_q | Call_Req;
        travel_d  = travel_q;
        door_d    = door_q;
`ifdef ELEVATOR_SCAN_EN
        dir_up_d  = dir_up_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (Top_Limit_Hit) begin
                    floor_d = TOP_FLOOR;
                end else if (Bottom_Limit_Hit) begin
                    floor_d = '0;
                end else if (has_pend) begin
                    if (target > floor_q) begin
                        state_d  = S_UP;
                        travel_d = '0;
`ifdef ELEVATOR_SCAN_EN
                        dir_up_d = 1'b1;
`endif
                    end else if (target < floor_q) begin
                        state_d  = S_DOWN;
                        travel_d = '0;
`ifdef ELEVATOR_SCAN_EN
                        dir_up_d = 1'b0;
`endif
                    end else begin
                        state_d = S_DOOR;
                    end
                end
            end
            S_UP, S_DOWN: begin
                if (Top_Limit_Hit || Bottom_Limit_Hit) begin
                    floor_d  = Top_Limit_Hit ? TOP_FLOOR : '0;
                    travel_d = '0;
                    state_d  = pending_d[floor_d] ? S_DOOR : S_IDLE;
                end else if (travel_q == TRAVEL_LAST) begin
                    travel_d = '0;
                    if (state_q == S_UP && floor_q != TOP_FLOOR) floor_d = floor_q + FW'(1);
                    if (state_q == S_DOWN && floor_q != '0)      floor_d = floor_q - FW'(1);
                    if (pending_d[floor_d]) begin
                        state_d = S_DOOR;
                    end else if ((state_q == S_UP && floor_d == TOP_FLOOR) ||
                                 (state_q == S_DOWN && floor_d == '0)) begin
                        state_d = S_IDLE;
                    end
                end else begin
                    travel_d = travel_q + TW'(1);
                end
            end
            S_DOOR: begin
                if (Top_Limit_Hit)         floor_d = TOP_FLOOR;
                else if (Bottom_Limit_Hit) floor_d = '0;
                if (door_q == DOOR_LAST) begin
                    state_d = S_IDLE;
                    door_d  = '0;
                end else if (Call_Req[floor_q]) begin
                    // A call at the open floor holds the door rather than queueing a revisit
                    door_d               = '0;
                    pending_d[floor_q]   = pending_q[floor_q];
                end else begin
                    door_d = door_q + DW'(1);
                end
            end
            S_HALTED: state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase

        if (Halt || dbl_limit) begin
            state_d   = S_HALTED;
            floor_d   = floor_q;
            travel_d  = '0;
            door_d    = '0;
            pending_d = pending_q | Call_Req;
        end else if (state_d == S_DOOR && state_q != S_DOOR) begin
            pending_d[floor_d] = 1'b0;
            door_d             = '0;
        end
    end

    always_comb begin
        go_up_d     = (state_d == S_UP);
        go_dn_d     = (state_d == S_DOWN);
        door_open_d = (state_d == S_DOOR);
    end

    assign Go_Up     = go_up_q;
    assign Go_Down   = go_dn_q;
    assign Door_Open = door_open_q;
    assign Floor     = floor_q;
    assign state     = state_q;

endmodule

// File: tb/tb_elevator_ctrl.sv
// Table-driven bench for elevator_ctrl with a queue scoreboard of expected states, floors and pending calls.
module tb_elevator_ctrl;

    localparam logic [4:0] I = 5'b00001;
    localparam logic [4:0] U = 5'b00010;
    localparam logic [4:0] D = 5'b00100;
    localparam logic [4:0] O = 5'b01000;
    localparam logic [4:0] H = 5'b10000;

    typedef struct packed {
        logic [4:0] st;
        logic [2:0] fl;
        logic [7:0] pend;
    } exp_t;

    typedef struct {
        logic       rst;
        logic [7:0] call;
        logic       halt;
        logic       top;
        logic       bot;
        int         cyc;
        exp_t       exp;
    } vec_t;

    logic       CLK = 1'b0;
    logic       RESET;
    logic [7:0] Call_Req;
    logic       Halt;
    logic       Top_Limit_Hit;
    logic       Bottom_Limit_Hit;
    logic       Go_Up;
    logic       Go_Down;
    logic       Door_Open;
    logic [2:0] Floor;
    logic [4:0] state;

    vec_t vecs[$];
    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    elevator_ctrl #(.FLOORS(8), .TRAVEL_CYCLES(4), .DOOR_CYCLES(3)) dut (
        .CLK              (CLK),
        .RESET            (RESET),
        .Call_Req         (Call_Req),
        .Halt             (Halt),
        .Top_Limit_Hit    (Top_Limit_Hit),
        .Bottom_Limit_Hit (Bottom_Limit_Hit),
        .Go_Up            (Go_Up),
        .Go_Down          (Go_Down),
        .Door_Open        (Door_Open),
        .Floor            (Floor),
        .state            (state)
    );

    always #5 CLK = ~CLK;

    // cyc = 0 means: apply inputs and sample 2 time units later with no clock edge in between
    task automatic add(input logic r, input logic [7:0] c, input logic h, input logic t, input logic b,
                       input int n, input logic [4:0] s, input logic [2:0] f, input logic [7:0] p);
        vec_t v;
        v.rst      = r;
        v.call     = c;
        v.halt     = h;
        v.top      = t;
        v.bot      = b;
        v.cyc      = n;
        v.exp.st   = s;
        v.exp.fl   = f;
        v.exp.pend = p;
        vecs.push_back(v);
    endtask

    initial begin
        exp_t        e;
        logic [18:0] act;
        logic [18:0] want;

        RESET = 1'b1; Call_Req = '0; Halt = 1'b0; Top_Limit_Hit = 1'b0; Bottom_Limit_Hit = 1'b0;

        // reset state
        add(1, 8'h00, 0, 0, 0, 2,  I, 0, 8'h00);
        // single call to floor 3: 12 cycles of travel, 3 cycles of door
        add(0, 8'h08, 0, 0, 0, 1,  I, 0, 8'h08);
        add(0, 8'h00, 0, 0, 0, 1,  U, 0, 8'h08);
        add(0, 8'h00, 0, 0, 0, 11, U, 2, 8'h08);
        add(0, 8'h00, 0, 0, 0, 1,  O, 3, 8'h00);
        add(0, 8'h00, 0, 0, 0, 2,  O, 3, 8'h00);
        add(0, 8'h00, 0, 0, 0, 1,  I, 3, 8'h00);
        // halt mid-travel, then resume to floor 6
        add(0, 8'h40, 0, 0, 0, 1,  I, 3, 8'h40);
        add(0, 8'h00, 0, 0, 0, 1,  U, 3, 8'h40);
        add(0, 8'h00, 0, 0, 0, 1,  U, 3, 8'h40);
        add(0, 8'h00, 1, 0, 0, 1,  H, 3, 8'h40);
        add(0, 8'h00, 1, 0, 0, 2,  H, 3, 8'h40);
        add(0, 8'h00, 0, 0, 0, 1,  I, 3, 8'h40);
        add(0, 8'h00, 0, 0, 0, 1,  U, 3, 8'h40);
        add(0, 8'h00, 0, 0, 0, 11, U, 5, 8'h40);
        add(0, 8'h00, 0, 0, 0, 1,  O, 6, 8'h00);
        add(0, 8'h00, 0, 0, 0, 3,  I, 6, 8'h00);
        // top limit while moving up with a call at 7
        add(0, 8'h00, 0, 0, 1, 1,  I, 0, 8'h00);
        add(0, 8'h10, 0, 0, 0, 1,  I, 0, 8'h10);
        add(0, 8'h00, 0, 0, 0, 1,  U, 0, 8'h10);
        add(0, 8'h00, 0, 0, 0, 8,  U, 2, 8'h10);
        add(0, 8'h80, 0, 0, 0, 1,  U, 2, 8'h90);
        add(0, 8'h00, 0, 1, 0, 1,  O, 7, 8'h10);
        add(0, 8'h00, 0, 0, 0, 2,  O, 7, 8'h10);
        add(0, 8'h00, 0, 0, 0, 1,  I, 7, 8'h10);
        add(0, 8'h00, 0, 0, 0, 1,  D, 7, 8'h10);
        add(0, 8'h00, 0, 0, 0, 11, D, 5, 8'h10);
        add(0, 8'h00, 0, 0, 0, 1,  O, 4, 8'h00);
        add(0, 8'h00, 0, 0, 0, 3,  I, 4, 8'h00);
        // calls at 1 and 5 with the car at 3 after moving up
        add(0, 8'h00, 0, 0, 1, 1,  I, 0, 8'h00);
        add(0, 8'h08, 0, 0, 0, 1,  I, 0, 8'h08);
        add(0, 8'h00, 0, 0, 0, 1,  U, 0, 8'h08);
        add(0, 8'h00, 0, 0, 0, 11, U, 2, 8'h08);
        add(0, 8'h00, 0, 0, 0, 1,  O, 3, 8'h00);
        add(0, 8'h22, 0, 0, 0, 1,  O, 3, 8'h22);
        add(0, 8'h00, 0, 0, 0, 2,  I, 3, 8'h22);
`ifdef ELEVATOR_SCAN_EN
        add(0, 8'h00, 0, 0, 0, 1,  U, 3, 8'h22);
        add(0, 8'h00, 0, 0, 0, 7,  U, 4, 8'h22);
        add(0, 8'h00, 0, 0, 0, 1,  O, 5, 8'h02);
        add(0, 8'h00, 0, 0, 0, 3,  I, 5, 8'h02);
        add(0, 8'h00, 0, 0, 0, 1,  D, 5, 8'h02);
        add(0, 8'h00, 0, 0, 0, 15, D, 2, 8'h02);
        add(0, 8'h00, 0, 0, 0, 1,  O, 1, 8'h00);
        add(0, 8'h00, 0, 0, 0, 3,  I, 1, 8'h00);
`else
        add(0, 8'h00, 0, 0, 0, 1,  D, 3, 8'h22);
        add(0, 8'h00, 0, 0, 0, 4,  D, 2, 8'h22);
        add(0, 8'h00, 0, 0, 0, 4,  O, 1, 8'h20);
        add(0, 8'h00, 0, 0, 0, 3,  I, 1, 8'h20);
        add(0, 8'h00, 0, 0, 0, 1,  U, 1, 8'h20);
        add(0, 8'h00, 0, 0, 0, 15, U, 4, 8'h20);
        add(0, 8'h00, 0, 0, 0, 1,  O, 5, 8'h00);
        add(0, 8'h00, 0, 0, 0, 3,  I, 5, 8'h00);
`endif
        // call at the open floor restarts the door timer without queueing
        add(0, 8'h00, 0, 0, 1, 1,  I, 0, 8'h00);
        add(0, 8'h01, 0, 0, 0, 1,  I, 0, 8'h01);
        add(0, 8'h00, 0, 0, 0, 1,  O, 0, 8'h00);
        add(0, 8'h00, 0, 0, 0, 1,  O, 0, 8'h00);
        add(0, 8'h01, 0, 0, 0, 1,  O, 0, 8'h00);
        add(0, 8'h00, 0, 0, 0, 2,  O, 0, 8'h00);
        add(0, 8'h00, 0, 0, 0, 1,  I, 0, 8'h00);
        // double limit fault, then asynchronous reset during door
        add(0, 8'h80, 0, 0, 0, 1,  I, 0, 8'h80);
        add(0, 8'h00, 0, 0, 0, 1,  U, 0, 8'h80);
        add(0, 8'h00, 0, 1, 1, 1,  H, 0, 8'h80);
        add(0, 8'h00, 0, 0, 0, 1,  I, 0, 8'h80);
        add(0, 8'h00, 0, 0, 0, 1,  U, 0, 8'h80);
        add(0, 8'h00, 0, 1, 0, 1,  O, 7, 8'h00);
        add(1, 8'h00, 0, 0, 0, 0,  I, 0, 8'h00);
        add(1, 8'h00, 0, 0, 0, 2,  I, 0, 8'h00);
        add(0, 8'h04, 0, 0, 0, 1,  I, 0, 8'h04);
        add(0, 8'h00, 0, 0, 0, 1,  U, 0, 8'h04);

        foreach (vecs[k]) begin
            RESET            = vecs[k].rst;
            Call_Req         = vecs[k].call;
            Halt             = vecs[k].halt;
            Top_Limit_Hit    = vecs[k].top;
            Bottom_Limit_Hit = vecs[k].bot;
            exp_q.push_back(vecs[k].exp);
            if (vecs[k].cyc == 0) begin
                #2;
            end else begin
                repeat (vecs[k].cyc) @(posedge CLK);
                #1;
            end
            e    = exp_q.pop_front();
            act  = {state, Floor, dut.pending_q, Go_Up, Go_Down, Door_Open};
            want = {e.st, e.fl, e.pend, e.st == U, e.st == D, e.st == O};
            checks++;
            if (act !== want) begin
                errors++;
                $display("FAIL row%0d: got state=%b floor=%0d pend=%h up/dn/door=%b%b%b, want state=%b floor=%0d pend=%h up/dn/door=%b%b%b",
                         k, state, Floor, dut.pending_q, Go_Up, Go_Down, Door_Open,
                         e.st, e.fl, e.pend, e.st == U, e.st == D, e.st == O);
            end
            checks++;
            if (Go_Up && Go_Down) begin
                errors++;
                $display("FAIL motor_excl row%0d: got up=%b dn=%b, want not both 1", k, Go_Up, Go_Down);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
